// File: rtl/mult_pkg.sv
// ==========================================================================
// mult_pkg: shared op codes, FSM states and helpers for mult_arbiter
// Rev 1.0
// ==========================================================================
`default_nettype none

package mult_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam int DEFAULT_TIMEOUT_CYC = 48;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_FIX   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_arbiter_rr_pick.sv
// ==========================================================================
// rr_pick: combinational round-robin picker, first request at/after ptr
// Rev 1.0
// ==========================================================================
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  logic          found;
  int            j;
  logic [IW-1:0] jj;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found     = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_arbiter.sv
// ==========================================================================
// mult_arbiter: round-robin RV32M sign-correcting front end for a shared
// unsigned 32x32 multiplier core.  Rev 1.0
// ==========================================================================
`default_nettype none

module mult_arbiter
  import mult_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [2*N_REQ-1:0]    req_op,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_accept,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  err_sticky,
  output logic                  m_init,
  output logic [31:0]           m_a,
  output logic [31:0]           m_b,
  input  logic                  m_ready,
  input  logic [31:0]           m_res_up,
  input  logic [31:0]           m_res_dn
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [1:0]    op_q;
  logic          neg_q;
  logic [CW-1:0] cnt;
  logic [63:0]   prod;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    win;
  logic [1:0]       win_op;
  logic [31:0]      win_a;
  logic [31:0]      win_b;
  logic             a_signed;
  logic             b_signed;
  logic [63:0]      prod_fix;
  logic [N_REQ-1:0] owner_oh;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win)
  );

  always_comb begin
    win_op   = req_op[2*int'(win) +: 2];
    win_a    = req_a[32*int'(win) +: 32];
    win_b    = req_b[32*int'(win) +: 32];
    a_signed = (win_op == OP_MULH) || (win_op == OP_MULHSU);
    b_signed = (win_op == OP_MULH);
    prod_fix = neg_q ? (~prod + 64'd1) : prod;
  end

  assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      op_q       <= OP_MUL;
      neg_q      <= 1'b0;
      cnt        <= '0;
      prod       <= '0;
      req_accept <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      err_sticky <= 1'b0;
      m_init     <= 1'b0;
      m_a        <= '0;
      m_b        <= '0;
    end else begin
      req_accept <= '0;
      rsp_valid  <= '0;
      rsp_err    <= 1'b0;
      m_init     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            req_accept <= grant;
            owner      <= win;
            op_q       <= win_op;
            neg_q      <= (a_signed & win_a[31]) ^ (b_signed & win_b[31]);
            m_a        <= magnitude(win_a, a_signed);
            m_b        <= magnitude(win_b, b_signed);
            m_init     <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A ready core beats a simultaneous timeout.
          if (m_ready) begin
            prod  <= {m_res_up, m_res_dn};
            state <= S_FIX;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            err_sticky <= 1'b1;
            rsp_data   <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= owner_oh;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          rsp_data  <= (op_q == OP_MUL) ? prod_fix[31:0] : prod_fix[63:32];
          rsp_valid <= owner_oh;
          state     <= S_RESP;
        end
        S_RESP: begin
          rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier core.
`default_nettype none

module tb_mult_arbiter;
  import mult_pkg::*;

  localparam int N  = 2;
  localparam int TO = 48;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [2*N-1:0]    req_op = '0;
  logic [32*N-1:0]   req_a = '0;
  logic [32*N-1:0]   req_b = '0;
  logic [N-1:0]      req_accept, rsp_valid;
  logic [31:0]       rsp_data, m_a, m_b, m_res_up, m_res_dn;
  logic              rsp_err, busy, err_sticky, m_init;
  logic              m_ready;

  mult_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_accept(req_accept), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .err_sticky(err_sticky),
    .m_init(m_init), .m_a(m_a), .m_b(m_b), .m_ready(m_ready),
    .m_res_up(m_res_up), .m_res_dn(m_res_dn)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: unsigned product, ready rises core_lat edges after init.
  int          core_lat  = 3;
  bit          core_dead = 1'b0;
  int          core_cnt;
  logic [63:0] core_prod;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ready   <= 1'b0;
      core_cnt  <= 0;
      core_prod <= '0;
    end else if (m_init) begin
      m_ready   <= 1'b0;
      core_cnt  <= core_lat;
      core_prod <= {32'b0, m_a} * {32'b0, m_b};
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_dead) m_ready <= 1'b1;
    end
  end
  assign m_res_up = core_prod[63:32];
  assign m_res_dn = core_prod[31:0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: full-width signed/unsigned product from the RV32M definitions.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (op == OP_MULH || op == OP_MULHSU) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (op == OP_MULH) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = sa * sb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output int t);
    bit got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (req_accept != 0) got = 1'b1;
    end
    t = cyc;
  endtask

  task automatic wait_rsp(input int bound, output int t);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      tick();
      if (rsp_valid != 0) got = 1'b1;
    end
    t = cyc;
  endtask

  task automatic drive(input int who, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_op[2*who +: 2] = op;
    req_a[32*who +: 32] = a;
    req_b[32*who +: 32] = b;
  endtask

  task automatic run_one(input int who, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input string name);
    int ta, tr;
    drive(who, op, a, b);
    req_valid[who] = 1'b1;
    wait_accept(ta);
    chk({name, " accept"}, req_accept, 64'(1 << who));
    req_valid[who] = 1'b0;
    wait_rsp(200, tr);
    chk({name, " rsp_valid"}, rsp_valid, 64'(1 << who));
    chk({name, " rsp_data"}, rsp_data, exp);
    chk({name, " rsp_err"}, rsp_err, 0);
    chk({name, " latency>=6"}, (tr - ta) >= 6, 1);
  endtask

  typedef struct {
    int          who;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ta, tr, own, seen;
    logic [1:0]  fop[2];
    logic [31:0] fa[2], fb[2];

    vecs[0] = '{0, OP_MUL,    32'h00000007, 32'h00000006, 32'h0000002A};
    vecs[1] = '{0, OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[2] = '{1, OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[3] = '{0, OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{1, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[5] = '{1, OP_MUL,    32'h80000000, 32'h00000002, 32'h00000000};
    vecs[6] = '{0, OP_MULH,   32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[7] = '{1, OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[8] = '{0, OP_MULH,   32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF};

    #2 reset = 1'b0;
    repeat (3) tick();
    chk("reset busy", busy, 0);
    chk("reset req_accept", req_accept, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset err_sticky", err_sticky, 0);
    chk("reset m_init", m_init, 0);
    chk("reset m_a", m_a, 0);
    chk("reset m_b", m_b, 0);
    reset = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++)
      run_one(vecs[i].who, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int who;
      who = $urandom_range(0, 1);
      op  = 2'($urandom);
      a   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      core_lat = $urandom_range(3, 8);
      run_one(who, op, a, b, ref_mul(op, a, b), $sformatf("rand%0d", i));
    end
    own = 0;  // last served was requester 0 or 1; recompute from fairness start below
    core_lat = 3;

    // Both requesters hold requests: grants must alternate.
    for (int r = 0; r < 2; r++) begin
      fop[r] = 2'($urandom);
      fa[r]  = $urandom;
      fb[r]  = $urandom;
      drive(r, fop[r], fa[r], fb[r]);
    end
    req_valid = 2'b11;
    wait_accept(ta);
    own = (req_accept == 2'b10) ? 1 : 0;
    chk("rr first accept onehot", (req_accept == 2'b01) || (req_accept == 2'b10), 1);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        wait_accept(ta);
        chk($sformatf("rr accept%0d", k), req_accept, 64'(1 << own));
      end
      chk($sformatf("rr busy%0d", k), busy, 1);
      wait_rsp(100, tr);
      if (k == 3) req_valid = '0;
      chk($sformatf("rr rsp_valid%0d", k), rsp_valid, 64'(1 << own));
      chk($sformatf("rr rsp_data%0d", k), rsp_data, ref_mul(fop[own], fa[own], fb[own]));
      own ^= 1;
    end

    // Dead core: timeout response exactly TO cycles after WAIT entry.
    tick();
    chk("pre-timeout err_sticky", err_sticky, 0);
    core_dead = 1'b1;
    drive(0, OP_MUL, 32'd2, 32'd3);
    req_valid[0] = 1'b1;
    wait_accept(ta);
    req_valid[0] = 1'b0;
    wait_rsp(TO + 20, tr);
    chk("timeout rsp_valid", rsp_valid, 1);
    chk("timeout rsp_err", rsp_err, 1);
    chk("timeout rsp_data", rsp_data, 0);
    chk("timeout delay", tr - (ta + 1), TO);
    chk("timeout err_sticky", err_sticky, 1);
    repeat (5) tick();
    chk("err_sticky holds", err_sticky, 1);
    chk("idle after timeout", busy, 0);

    // Reset in the middle of WAIT abandons the operation.
    core_dead = 1'b0;
    core_lat  = 30;
    drive(1, OP_MUL, 32'd9, 32'd9);
    req_valid[1] = 1'b1;
    wait_accept(ta);
    req_valid[1] = 1'b0;
    repeat (5) tick();
    chk("mid-wait busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst rsp_valid", rsp_valid, 0);
    chk("async rst m_a", m_a, 0);
    chk("async rst m_b", m_b, 0);
    chk("async rst err_sticky", err_sticky, 0);
    chk("async rst rsp_data", rsp_data, 0);
    repeat (2) tick();
    reset = 1'b1;
    core_lat = 3;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid != 0) seen++;
    end
    chk("no rsp after reset", seen, 0);
    run_one(0, OP_MUL, 32'd3, 32'd5, 32'h0000000F, "post-reset mul");
    run_one(1, OP_MULHU, 32'h12345678, 32'h9ABCDEF0,
            ref_mul(OP_MULHU, 32'h12345678, 32'h9ABCDEF0), "post-reset mulhu");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
